// File: rtl/time_counter.sv
// BCD time-of-day counter (hh:mm:ss, 24-hour) with run and set modes,
// a pre-hour chime window decode and a one-cycle hour rollover pulse.
module time_counter (
    input  logic       clk_1hz,
    input  logic       cr,
    input  logic       en_set,
    input  logic       min_hour,
    output logic [3:0] bcd_tsu,
    output logic [3:0] bcd_tst,
    output logic [3:0] bcd_tmu,
    output logic [3:0] bcd_tmt,
    output logic [3:0] bcd_thu,
    output logic [3:0] bcd_tht,
    output logic       chime,
    output logic       hour_pulse
);

    logic [3:0] nxt_tsu, nxt_tst, nxt_tmu, nxt_tmt, nxt_thu, nxt_tht;
    logic       nxt_pulse;
    logic       sec_max, min_max;

    // Advance a 00-59 BCD pair; returns {tens, units}.
    function automatic logic [7:0] inc_sixty(input logic [3:0] t, input logic [3:0] u);
        if (u == 4'd9) begin
            if (t == 4'd5) return '0;
            else           return {t + 4'd1, 4'd0};
        end
        return {t, u + 4'd1};
    endfunction

    // Advance a 00-23 BCD pair; returns {tens, units}.
    function automatic logic [7:0] inc_hour(input logic [3:0] t, input logic [3:0] u);
        if (t == 4'd2 && u == 4'd3) return '0;
        if (u == 4'd9)              return {t + 4'd1, 4'd0};
        return {t, u + 4'd1};
    endfunction

    assign sec_max = (bcd_tst == 4'd5) && (bcd_tsu == 4'd9);
    assign min_max = (bcd_tmt == 4'd5) && (bcd_tmu == 4'd9);

    always_comb begin
        nxt_tsu   = bcd_tsu;
        nxt_tst   = bcd_tst;
        nxt_tmu   = bcd_tmu;
        nxt_tmt   = bcd_tmt;
        nxt_thu   = bcd_thu;
        nxt_tht   = bcd_tht;
        nxt_pulse = 1'b0;
        if (en_set) begin
            // Set mode: seconds parked at 00, the selected field steps with no carry.
            nxt_tsu = '0;
            nxt_tst = '0;
            if (!min_hour) {nxt_tmt, nxt_tmu} = inc_sixty(bcd_tmt, bcd_tmu);
            else           {nxt_tht, nxt_thu} = inc_hour(bcd_tht, bcd_thu);
        end else begin
            {nxt_tst, nxt_tsu} = inc_sixty(bcd_tst, bcd_tsu);
            if (sec_max) {nxt_tmt, nxt_tmu} = inc_sixty(bcd_tmt, bcd_tmu);
            if (sec_max && min_max) begin
                {nxt_tht, nxt_thu} = inc_hour(bcd_tht, bcd_thu);
                nxt_pulse = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_1hz) begin
        if (!cr) begin
            bcd_tsu    <= '0;
            bcd_tst    <= '0;
            bcd_tmu    <= '0;
            bcd_tmt    <= '0;
            bcd_thu    <= '0;
            bcd_tht    <= '0;
            hour_pulse <= 1'b0;
        end else begin
            bcd_tsu    <= nxt_tsu;
            bcd_tst    <= nxt_tst;
            bcd_tmu    <= nxt_tmu;
            bcd_tmt    <= nxt_tmt;
            bcd_thu    <= nxt_thu;
            bcd_tht    <= nxt_tht;
            hour_pulse <= nxt_pulse;
        end
    end

    assign chime = !en_set && min_max && (bcd_tst == 4'd5);

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter: a vector table for single-edge behaviour
// plus hand-written sequences for rollover, chime window and set/reset corners.
module tb_time_counter;

    logic       clk_1hz = 1'b0;
    logic       cr = 1'b0, en_set = 1'b0, min_hour = 1'b0;
    logic [3:0] bcd_tsu, bcd_tst, bcd_tmu, bcd_tmt, bcd_thu, bcd_tht;
    logic       chime, hour_pulse;

    int vectors = 0;
    int errors  = 0;

    // Reference time, kept as plain integers.
    int eh = 0, em = 0, es = 0;
    logic ehp = 1'b0;

    time_counter dut (
        .clk_1hz   (clk_1hz),
        .cr        (cr),
        .en_set    (en_set),
        .min_hour  (min_hour),
        .bcd_tsu   (bcd_tsu),
        .bcd_tst   (bcd_tst),
        .bcd_tmu   (bcd_tmu),
        .bcd_tmt   (bcd_tmt),
        .bcd_thu   (bcd_thu),
        .bcd_tht   (bcd_tht),
        .chime     (chime),
        .hour_pulse(hour_pulse)
    );

    always #5 clk_1hz = ~clk_1hz;

    typedef struct {
        logic c;
        logic e;
        logic m;
        int   h;
        int   mi;
        int   s;
        logic ch;
        logic hp;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [23:0] to_bcd(input int h, input int m, input int s);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic check(input string name, input int h, input int m, input int s,
                         input logic ch, input logic hp);
        logic [23:0] act, req;
        act = {bcd_tht, bcd_thu, bcd_tmt, bcd_tmu, bcd_tst, bcd_tsu};
        req = to_bcd(h, m, s);
        vectors++;
        if (act !== req || chime !== ch || hour_pulse !== hp) begin
            errors++;
            $display("FAIL %s: got time=%h chime=%b hour_pulse=%b, want time=%h chime=%b hour_pulse=%b",
                     name, act, chime, hour_pulse, req, ch, hp);
        end
    endtask

    // Apply one edge and advance the reference model.
    task automatic step(input logic c, input logic e, input logic m);
        int t;
        @(negedge clk_1hz);
        cr = c; en_set = e; min_hour = m;
        @(posedge clk_1hz);
        #1;
        if (!c) begin
            eh = 0; em = 0; es = 0; ehp = 1'b0;
        end else if (e) begin
            es = 0; ehp = 1'b0;
            if (!m) em = (em + 1) % 60;
            else    eh = (eh + 1) % 24;
        end else begin
            t  = (eh * 3600 + em * 60 + es + 1) % 86400;
            eh = t / 3600; em = (t / 60) % 60; es = t % 60;
            ehp = (em == 0) && (es == 0);
        end
    endtask

    function automatic logic model_chime();
        return !en_set && (em == 59) && (es >= 50);
    endfunction

    task automatic check_model(input string name);
        check(name, eh, em, es, model_chime(), ehp);
    endtask

    task automatic repeat_step(input int n, input logic e, input logic m);
        for (int i = 0; i < n; i++) step(1'b1, e, m);
    endtask

    initial begin
        //             cr    en    mh    hh  mm  ss  chime hp
        tbl[0] = '{1'b0, 1'b0, 1'b0,  0,  0,  0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0,  0,  0,  1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b0,  0,  1,  0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b1,  1,  1,  0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b1,  1,  1,  1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b1,  0,  0,  0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b1,  1,  0,  0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b1,  0,  0,  0, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 1'b0,  0,  1,  0, 1'b0, 1'b0};
        tbl[9] = '{1'b1, 1'b0, 1'b0,  0,  1,  1, 1'b0, 1'b0};

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].c, tbl[i].e, tbl[i].m);
            check($sformatf("table[%0d]", i), tbl[i].h, tbl[i].mi, tbl[i].s, tbl[i].ch, tbl[i].hp);
        end

        // 75 run edges from reset; no chime, no hour pulse along the way
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 75; i++) begin
            step(1'b1, 1'b0, 1'b0);
            check_model("run75_edge");
        end
        check("run75_final", 0, 1, 15, 1'b0, 1'b0);

        // Chime window across 12:59:50 .. 13:00:00
        step(1'b0, 1'b0, 1'b0);
        repeat_step(12, 1'b1, 1'b1);
        repeat_step(59, 1'b1, 1'b0);
        repeat_step(49, 1'b0, 1'b0);
        check("preload_125949", 12, 59, 49, 1'b0, 1'b0);
        for (int i = 1; i <= 11; i++) begin
            step(1'b1, 1'b0, 1'b0);
            check_model("chime_window");
        end
        check("chime_end_1300", 13, 0, 0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        check("pulse_drop_130001", 13, 0, 1, 1'b0, 1'b0);

        // Midnight rollover
        step(1'b0, 1'b0, 1'b0);
        repeat_step(23, 1'b1, 1'b1);
        repeat_step(59, 1'b1, 1'b0);
        repeat_step(59, 1'b0, 1'b0);
        check("pre_midnight", 23, 59, 59, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("midnight", 0, 0, 0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        check("after_midnight", 0, 0, 1, 1'b0, 1'b0);

        // Set-mode wraps never pulse or carry
        step(1'b0, 1'b0, 1'b0);
        repeat_step(58, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0);
            check_model("set_min_wrap");
        end
        check("set_min_final", 0, 1, 0, 1'b0, 1'b0);
        repeat_step(22, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1);
            check_model("set_hour_wrap");
        end
        check("set_hour_final", 1, 1, 0, 1'b0, 1'b0);

        // Entering set mode inside the chime window masks chime
        step(1'b0, 1'b0, 1'b0);
        repeat_step(59, 1'b1, 1'b0);
        repeat_step(55, 1'b0, 1'b0);
        check("chime_at_5955", 0, 59, 55, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("set_in_window", 1, 59, 0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("resume_run", 1, 59, 1, 1'b0, 1'b0);

        // Clear beats set mode mid-adjust
        step(1'b0, 1'b0, 1'b0);
        repeat_step(15, 1'b1, 1'b1);
        repeat_step(42, 1'b1, 1'b0);
        repeat_step(37, 1'b0, 1'b0);
        check("at_154237", 15, 42, 37, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("clear_in_set", 0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("release_set_min", 0, 1, 0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/time_counter.md
TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state SHALL change only on the rising edge of clk_1hz.
REQ-002 clk_1hz  input  1  timekeeping clock, one rising edge per second.
REQ-003 cr  input  1  synchronous active-low clear; sampled on rising clk_1hz.
REQ-004 en_set  input  1  1 = set mode (time frozen, field adjust); 0 = run mode.
REQ-005 min_hour  input  1  set-mode field select: 0 = minutes, 1 = hours.
REQ-006 bcd_tsu / bcd_tst  output  4 each  seconds units / tens, BCD.
REQ-007 bcd_tmu / bcd_tmt  output  4 each  minutes units / tens, BCD; consumed by the alarm comparator.
REQ-008 bcd_thu / bcd_tht  output  4 each  hours units / tens, BCD, 24-hour format; consumed by the alarm comparator.
REQ-009 chime  output  1  pre-hour chime window flag.
REQ-010 hour_pulse  output  1  one-cycle flag on each run-mode hour rollover.

Function
REQ-011 Time digits SHALL be registered; ranges: seconds 00-59, minutes 00-59, hours 00-23; each digit SHALL hold BCD values 0-9 only.
REQ-012 Run mode (en_set=0): each edge SHALL advance seconds by 1.
REQ-013 Seconds units 9 -> 0 with tens +1; seconds 59 -> 00 with carry into minutes on the same edge.
REQ-014 Minutes 59 -> 00 with carry into hours on the same edge; minutes units 9 -> 0 with tens +1 otherwise.
REQ-015 Hours SHALL count 09 -> 10, 19 -> 20, 23 -> 00; 23:59:59 SHALL become 00:00:00 in one edge.
REQ-016 Set mode (en_set=1): seconds SHALL be loaded with 00 on every edge; no carry SHALL propagate between fields.
REQ-017 Set mode, min_hour=0: minutes SHALL increment by 1 per edge, wrapping 59 -> 00; hours unchanged.
REQ-018 Set mode, min_hour=1: hours SHALL increment by 1 per edge, wrapping 23 -> 00; minutes unchanged.
REQ-019 min_hour SHALL be ignored in run mode.
REQ-020 On en_set 1 -> 0, the first run-mode edge SHALL advance seconds 00 -> 01 from the value set.
REQ-021 chime SHALL be a combinational decode of registered state: 1 when en_set=0, minutes=59 and seconds tens=5 (xx:59:50 through xx:59:59); else 0.
REQ-022 hour_pulse SHALL be registered and SHALL be 1 for exactly the one cycle following a run-mode edge that carried minutes 59 -> 00 (i.e. while time reads hh:00:00); 0 otherwise.
REQ-023 hour_pulse SHALL NOT assert due to set-mode wraps or reset.
REQ-024 Outputs SHALL be valid (settled) within the same clock period as the edge that updated them; latency from edge to digit change is zero cycles.

Reset
REQ-025 cr=0 at a rising edge SHALL load all time digits with 0 (00:00:00) and clear hour_pulse to 0; chime therefore reads 0.
REQ-026 cr SHALL have priority over en_set and min_hour; reset applied mid-count or mid-set SHALL take effect on that edge with no partial update.
REQ-027 After cr returns to 1, the first edge SHALL produce 00:00:01 (run mode) or 00:01:00 / 01:00:00 (set mode, min_hour=0 / 1).
REQ-028 Without reset, register contents SHALL be treated as unknown; the bench SHALL apply cr=0 for at least one edge first.

Verification
REQ-029 Reset, run 75 edges -> time 00:01:15; chime=0; hour_pulse never 1.
REQ-030 Preload 12:59:49 via set mode, run 11 edges -> chime rises at 12:59:50, holds 10 cycles, falls at 13:00:00; hour_pulse=1 only at 13:00:00.
REQ-031 Time 23:59:59, one run edge -> 00:00:00, hour_pulse=1 next cycle only.
REQ-032 Set mode min_hour=0 from 00:58:xx, 3 edges -> 00:01:00, hours still 00, hour_pulse=0; min_hour=1 from 22, 3 edges -> 01:01:00.
REQ-033 Set mode during xx:59:55 -> chime drops to 0 on the set edge; seconds read 00.
REQ-034 cr=0 asserted at 15:42:37 with en_set=1 -> 00:00:00 on that edge; release -> next edge per REQ-027.
